// File: rtl/fft_cp_strip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_cp_strip_pkg
//  Description : Shared constants and state encoding for the cyclic-prefix
//                stripping framer that feeds the fft top level.
//  Revision    : 1.0 - initial release
// ============================================================================

// Sample width normally comes from fixed_point.v; fall back to 16 bits when
// this package is compiled without it.
`ifndef FFT_IN_WIDTH
`define FFT_IN_WIDTH 16
`endif

package fft_cp_strip_pkg;

    localparam int C_FFT_IN_WIDTH = `FFT_IN_WIDTH;
    localparam int C_CP_WIDTH     = 11;
    localparam int C_LDN_MIN      = 2;
    localparam int C_LDN_MAX      = 11;

    // Framer states, fixed encoding so debug taps read consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    // True when ldn lies inside the supported FFT size range.
    function automatic logic ldn_legal(input logic [3:0] ldn,
                                       input int        lo,
                                       input int        hi);
        return (int'(ldn) >= lo) && (int'(ldn) <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_cp_strip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_cp_strip_ctrl
//  Description : Symbol framing FSM and sample counter. Decides, per valid
//                input sample, whether it is kept, whether it is the first
//                kept sample of a block, and whether an error is flagged.
//                Also holds the ldn latched for the current symbol.
//  Ports       : clk_sys, rst_sys_n   - clock, async active-low reset
//                sym_start_i          - symbol start marker
//                data_val_i           - input sample valid
//                ldn_rg_i, cp_len_i   - size / CP length for next symbol
//                keep_o, first_o,     - combinational per-sample strobes
//                err_o
//                ldn_q_o              - registered ldn of current symbol
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_cp_strip_ctrl
    import fft_cp_strip_pkg::*;
#(
    parameter int CP_WIDTH = C_CP_WIDTH,
    parameter int LDN_MIN  = C_LDN_MIN,
    parameter int LDN_MAX  = C_LDN_MAX
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                sym_start_i,
    input  logic                data_val_i,
    input  logic [3:0]          ldn_rg_i,
    input  logic [CP_WIDTH-1:0] cp_len_i,
    output logic                keep_o,
    output logic                first_o,
    output logic                err_o,
    output logic [3:0]          ldn_q_o
);

    localparam int CNT_W = (CP_WIDTH > LDN_MAX + 1) ? CP_WIDTH : LDN_MAX + 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CP_WIDTH-1:0] r_cp;
    logic [3:0]          r_ldn;

    logic                w_st;
    logic                w_last;
    logic                w_restart;
    logic                w_ldn_ok;
    logic                w_skip_done;
    logic                w_cp_zero;
    logic [11:0]         w_n;
    logic [11:0]         w_last_idx;

    assign w_st        = sym_start_i & data_val_i;
    assign w_n         = 12'd1 << r_ldn;
    assign w_last_idx  = w_n - 12'd1;
    assign w_last      = (r_state == ST_PASS) && (r_cnt == CNT_W'(w_last_idx));
    // A start coinciding with the final sample of a block is not a new start.
    assign w_restart   = w_st & ~w_last;
    assign w_ldn_ok    = ldn_legal(ldn_rg_i, LDN_MIN, LDN_MAX);
    assign w_skip_done = (r_cnt == CNT_W'(r_cp));
    assign w_cp_zero   = (cp_len_i == '0);
    assign ldn_q_o     = r_ldn;

    always_comb begin
        keep_o  = 1'b0;
        first_o = 1'b0;
        err_o   = 1'b0;
        if (w_restart) begin
            // Starting while a block is in flight is an abort.
            err_o   = (r_state != ST_IDLE) | ~w_ldn_ok;
            keep_o  = w_ldn_ok & w_cp_zero;
            first_o = w_ldn_ok & w_cp_zero;
        end else if (data_val_i) begin
            case (r_state)
                ST_SKIP: begin
                    keep_o  = w_skip_done;
                    first_o = w_skip_done;
                end
                ST_PASS: keep_o = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cp    <= '0;
            r_ldn   <= '0;
        end else if (data_val_i) begin
            if (w_restart) begin
                if (w_ldn_ok) begin
                    r_ldn   <= ldn_rg_i;
                    r_cp    <= cp_len_i;
                    r_cnt   <= CNT_W'(1);
                    r_state <= w_cp_zero ? ST_PASS : ST_SKIP;
                end else begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            end else begin
                case (r_state)
                    ST_SKIP: begin
                        if (w_skip_done) begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_PASS;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_PASS: begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_cp_strip.sv
`default_nettype none
// ============================================================================
//  Module      : fft_cp_strip
//  Description : Cyclic-prefix stripping framer ahead of fixed2bfp / fft.
//                Drops the CP of each OFDM symbol and emits exactly 2^ldn
//                samples with block_sync/data_val framing, one cycle after
//                the corresponding input sample.
//  Ports       : clk_sys, rst_sys_n           - clock, async active-low reset
//                sym_start_i, data_val_i      - input framing
//                data_real_i, data_imag_i     - input sample
//                ldn_rg_i, cp_len_i           - next-symbol configuration
//                block_sync_o, data_val_o     - output framing
//                data_real_o, data_imag_o     - kept sample
//                ldn_rg_o                     - ldn of current symbol
//                err_o                        - abort / illegal ldn pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_cp_strip
    import fft_cp_strip_pkg::*;
#(
    parameter int IN_WIDTH = C_FFT_IN_WIDTH,
    parameter int CP_WIDTH = C_CP_WIDTH,
    parameter int LDN_MIN  = C_LDN_MIN,
    parameter int LDN_MAX  = C_LDN_MAX
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                sym_start_i,
    input  logic                data_val_i,
    input  logic [IN_WIDTH-1:0] data_real_i,
    input  logic [IN_WIDTH-1:0] data_imag_i,
    input  logic [3:0]          ldn_rg_i,
    input  logic [CP_WIDTH-1:0] cp_len_i,
    output logic                block_sync_o,
    output logic                data_val_o,
    output logic [IN_WIDTH-1:0] data_real_o,
    output logic [IN_WIDTH-1:0] data_imag_o,
    output logic [3:0]          ldn_rg_o,
    output logic                err_o
);

    logic                w_keep;
    logic                w_first;
    logic                w_err;

    logic                r_sync;
    logic                r_val;
    logic                r_err;
    logic [IN_WIDTH-1:0] r_real;
    logic [IN_WIDTH-1:0] r_imag;

    fft_cp_strip_ctrl #(
        .CP_WIDTH (CP_WIDTH),
        .LDN_MIN  (LDN_MIN),
        .LDN_MAX  (LDN_MAX)
    ) u_ctrl (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .sym_start_i (sym_start_i),
        .data_val_i  (data_val_i),
        .ldn_rg_i    (ldn_rg_i),
        .cp_len_i    (cp_len_i),
        .keep_o      (w_keep),
        .first_o     (w_first),
        .err_o       (w_err),
        .ldn_q_o     (ldn_rg_o)
    );

    // Sample data only loads on kept samples so the bus holds steady in gaps.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_sync <= 1'b0;
            r_val  <= 1'b0;
            r_err  <= 1'b0;
            r_real <= '0;
            r_imag <= '0;
        end else begin
            r_sync <= w_first;
            r_val  <= w_keep;
            r_err  <= w_err;
            if (w_keep) begin
                r_real <= data_real_i;
                r_imag <= data_imag_i;
            end
        end
    end

    assign block_sync_o = r_sync;
    assign data_val_o   = r_val;
    assign err_o        = r_err;
    assign data_real_o  = r_real;
    assign data_imag_o  = r_imag;

endmodule

`default_nettype wire
